reg_seq_ctrl: RTL and testbench

REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

---
 rtl/reg_seq_ctrl_if.sv | 35 +++
 rtl/reg_seq_ctrl.sv | 106 ++++++++++
 tb/tb_reg_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_seq_ctrl_if.sv
// Instruction handshake bundle for reg_seq_ctrl.
// INS_LI/INS_IMM exist only when REG_SEQ_LOADI_EN is defined.
interface reg_seq_ctrl_if;
  logic       INS_VALID;
  logic       INS_READY;
  logic [1:0] INS_RS1;
  logic [1:0] INS_RS2;
  logic [1:0] INS_RD;
`ifdef REG_SEQ_LOADI_EN
  logic       INS_LI;
  logic [7:0] INS_IMM;

  modport master (
    output INS_VALID, INS_RS1, INS_RS2,
    output INS_RD, INS_LI, INS_IMM,
    input  INS_READY
  );
  modport slave (
    input  INS_VALID, INS_RS1, INS_RS2,
    input  INS_RD, INS_LI, INS_IMM,
    output INS_READY
  );
`else
  modport master (
    output INS_VALID, INS_RS1, INS_RS2,
    output INS_RD,
    input  INS_READY
  );
  modport slave (
    input  INS_VALID, INS_RS1, INS_RS2,
    input  INS_RD,
    output INS_READY
  );
`endif
endinterface

// File: rtl/reg_seq_ctrl.sv
// IDLE/READ/EXEC/WRITE register-file sequencer around an external ALU.
// Define REG_SEQ_LOADI_EN to add the load-immediate (IDLE->WRITE) path.
module reg_seq_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_seq_ctrl_if.slave ins,
  output logic [1:0]    RF_DIR_A,
  output logic [1:0]    RF_DIR_B,
  output logic [1:0]    RF_DIR_WR,
  output logic          RF_EN,
  output logic [7:0]    RF_DI,
  input  logic [7:0]    RF_DOA,
  input  logic [7:0]    RF_DOB,
  output logic [7:0]    ALU_A,
  output logic [7:0]    ALU_B,
  input  logic [7:0]    ALU_RES,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  logic [1:0] state;
  logic [1:0] rs1_q;
  logic [1:0] rs2_q;
  logic [1:0] rd_q;
  logic [3:0] cnt;
  logic [7:0] res_q;
  logic       done_q;
  logic       accept;
  logic       li;
  logic [7:0] imm;

`ifdef REG_SEQ_LOADI_EN
  assign li  = ins.INS_LI;
  assign imm = ins.INS_IMM;
`else
  assign li  = 1'b0;
  assign imm = 8'h00;
`endif

  // Gate with rst_n so READY is low while reset is held.
  assign ins.INS_READY = rst_n & (state == IDLE);
  assign accept = ins.INS_VALID & ins.INS_READY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rs1_q  <= 2'd0;
      rs2_q  <= 2'd0;
      rd_q   <= 2'd0;
      cnt    <= 4'd0;
      res_q  <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == WRITE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            rs1_q <= ins.INS_RS1;
            rs2_q <= ins.INS_RS2;
            rd_q  <= ins.INS_RD;
            if (li) begin
              res_q <= imm;
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          cnt   <= CNT_INIT;
          state <= EXEC;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            res_q <= ALU_RES;
            state <= WRITE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign RF_DIR_A  = rs1_q;
  assign RF_DIR_B  = rs2_q;
  assign RF_DIR_WR = rd_q;
  assign RF_DI     = res_q;
  assign RF_EN     = (state == WRITE);
  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign ALU_A     = (state == EXEC) ? RF_DOA : 8'h00;
  assign ALU_B     = (state == EXEC) ? RF_DOB : 8'h00;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: ALU_LAT=1 and ALU_LAT=4 instances side by side.
// Each instance has its own model register file and add/sub ALU.
module tb_reg_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic       v1, v4;
  logic [1:0] t_rs1, t_rs2, t_rd;
  logic       t_li;
  logic [7:0] t_imm;
  logic       alu_sub;
  logic       pre_en;
  logic [1:0] pre_a;
  logic [7:0] pre_d;

  reg_seq_ctrl_if i1();
  reg_seq_ctrl_if i4();

  assign i1.INS_VALID = v1;
  assign i1.INS_RS1   = t_rs1;
  assign i1.INS_RS2   = t_rs2;
  assign i1.INS_RD    = t_rd;
  assign i4.INS_VALID = v4;
  assign i4.INS_RS1   = t_rs1;
  assign i4.INS_RS2   = t_rs2;
  assign i4.INS_RD    = t_rd;
`ifdef REG_SEQ_LOADI_EN
  assign i1.INS_LI  = t_li;
  assign i1.INS_IMM = t_imm;
  assign i4.INS_LI  = t_li;
  assign i4.INS_IMM = t_imm;
`endif

  logic [1:0] da1, db1, dw1, da4, db4, dw4;
  logic       en1, en4, busy1, busy4, done1, done4;
  logic [7:0] di1, di4, doa1, dob1, doa4, dob4;
  logic [7:0] aa1, ab1, aa4, ab4, res1, res4;
  logic [7:0] rf1 [4];
  logic [7:0] rf4 [4];

  reg_seq_ctrl #(.ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ins(i1),
    .RF_DIR_A(da1), .RF_DIR_B(db1), .RF_DIR_WR(dw1),
    .RF_EN(en1), .RF_DI(di1),
    .RF_DOA(doa1), .RF_DOB(dob1),
    .ALU_A(aa1), .ALU_B(ab1), .ALU_RES(res1),
    .BUSY(busy1), .DONE(done1)
  );

  reg_seq_ctrl #(.ALU_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .ins(i4),
    .RF_DIR_A(da4), .RF_DIR_B(db4), .RF_DIR_WR(dw4),
    .RF_EN(en4), .RF_DI(di4),
    .RF_DOA(doa4), .RF_DOB(dob4),
    .ALU_A(aa4), .ALU_B(ab4), .ALU_RES(res4),
    .BUSY(busy4), .DONE(done4)
  );

  assign doa1 = rf1[da1];
  assign dob1 = rf1[db1];
  assign doa4 = rf4[da4];
  assign dob4 = rf4[db4];
  assign res1 = alu_sub ? aa1 - ab1 : aa1 + ab1;
  assign res4 = alu_sub ? aa4 - ab4 : aa4 + ab4;

  always @(posedge clk) begin
    if (pre_en) begin
      rf1[pre_a] <= pre_d;
      rf4[pre_a] <= pre_d;
    end else begin
      if (en1) rf1[dw1] <= di1;
      if (en4) rf4[dw4] <= di4;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] rd;
    logic       sub;
    logic       li;
    logic [7:0] imm;
    logic [7:0] exp_a;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int wc1, wc4, dc1, dc4, nw1, nw4;
    logic [1:0] w1, w4;
    logic [7:0] d1, d4, a1, a4, ar1;
    logic rdy1, rdy4;
    wc1 = -1; wc4 = -1; dc1 = -1; dc4 = -1;
    nw1 = 0; nw4 = 0;
    w1 = 0; w4 = 0; d1 = 0; d4 = 0;
    a1 = 0; a4 = 0; ar1 = 8'hFF;
    rdy1 = 0; rdy4 = 0;
    @(negedge clk);
    t_rs1 = v.rs1; t_rs2 = v.rs2; t_rd = v.rd;
    alu_sub = v.sub; t_li = v.li; t_imm = v.imm;
    v1 = 1'b1; v4 = 1'b1;
    chk("ready1_idle", i1.INS_READY, 1);
    chk("ready4_idle", i4.INS_READY, 1);
    @(posedge clk);
    #1 v1 = 1'b0; v4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (en1) begin nw1++; wc1 = c; w1 = dw1; d1 = di1; end
      if (en4) begin nw4++; wc4 = c; w4 = dw4; d4 = di4; end
      if (done1) begin dc1 = c; rdy1 = i1.INS_READY; end
      if (done4) begin dc4 = c; rdy4 = i4.INS_READY; end
      if (c == 1) ar1 = aa1;
      if (c == 2) begin a1 = aa1; a4 = aa4; end
    end
    chk("wr_cyc1", wc1, v.li ? 1 : 3);
    chk("wr_cyc4", wc4, v.li ? 1 : 6);
    chk("done_cyc1", dc1, v.li ? 2 : 4);
    chk("done_cyc4", dc4, v.li ? 2 : 7);
    chk("nwrites1", nw1, 1);
    chk("nwrites4", nw4, 1);
    chk("wr_addr1", w1, v.rd);
    chk("wr_addr4", w4, v.rd);
    chk("wr_data1", d1, v.exp_d);
    chk("wr_data4", d4, v.exp_d);
    chk("ready_at_done1", rdy1, 1);
    chk("ready_at_done4", rdy4, 1);
    chk("rf1_rd", rf1[v.rd], v.exp_d);
    chk("rf4_rd", rf4[v.rd], v.exp_d);
    if (!v.li) begin
      chk("alu_a_read1", ar1, 0);
      chk("alu_a_exec1", a1, v.exp_a);
      chk("alu_a_exec4", a4, v.exp_a);
    end
  endtask

  task automatic stream();
    int acc1, acc4, f1, f4, l1, l4, nw1, nw4, dn1, dn4;
    acc1 = 0; acc4 = 0; f1 = -1; f4 = -1; l1 = -1; l4 = -1;
    nw1 = 0; nw4 = 0; dn1 = 0; dn4 = 0;
    @(negedge clk);
    t_rs1 = 2'd1; t_rs2 = 2'd2; t_rd = 2'd0;
    alu_sub = 1'b0; t_li = 1'b0;
    v1 = 1'b1; v4 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (v1 && i1.INS_READY) begin
        if (acc1 == 0) f1 = cyc;
        acc1++;
        l1 = cyc;
      end
      if (v4 && i4.INS_READY) begin
        if (acc4 == 0) f4 = cyc;
        acc4++;
        l4 = cyc;
      end
      if (en1) nw1++;
      if (en4) nw4++;
      if (done1) dn1++;
      if (done4) dn4++;
      @(posedge clk);
      #1;
      v1 = (acc1 < 3);
      v4 = (acc4 < 3);
    end
    chk("stream_acc1", acc1, 3);
    chk("stream_acc4", acc4, 3);
    chk("stream_span1", l1 - f1, 8);
    chk("stream_span4", l4 - f4, 14);
    chk("stream_wr1", nw1, 3);
    chk("stream_wr4", nw4, 3);
    chk("stream_done1", dn1, 3);
    chk("stream_done4", dn4, 3);
    chk("stream_rf1", rf1[0], 8'h27);
    chk("stream_rf4", rf4[0], 8'h27);
  endtask

  task automatic reset_abort();
    int nw, nd;
    nw = 0; nd = 0;
    @(negedge clk);
    t_rs1 = 2'd1; t_rs2 = 2'd2; t_rd = 2'd3;
    alu_sub = 1'b0; t_li = 1'b0;
    v1 = 1'b1; v4 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0; v4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready1", i1.INS_READY, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_en1", en1, 0);
    chk("rst_dira4", da4, 0);
    chk("rst_di4", di4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("rel_ready1", i1.INS_READY, 1);
        chk("rel_ready4", i4.INS_READY, 1);
      end
      if (en1 || en4) nw++;
      if (done1 || done4) nd++;
    end
    chk("abort_writes", nw, 0);
    chk("abort_dones", nd, 0);
    chk("abort_rf1", rf1[3], 8'h00);
    chk("abort_rf4", rf4[3], 8'h00);
    chk("abort_rf1_x1", rf1[1], 8'h0F);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    v1 = 1'b0; v4 = 1'b0;
    t_rs1 = 0; t_rs2 = 0; t_rd = 0;
    t_li = 0; t_imm = 0; alu_sub = 0;
    pre_en = 0; pre_a = 0; pre_d = 0;

    vecs[0] = '{2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 8'h00, 8'h05, 8'h08};
    vecs[1] = '{2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h08, 8'h0D};
    vecs[2] = '{2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 8'h00, 8'h0D, 8'h08};
    vecs[3] = '{2'd0, 2'd3, 2'd3, 1'b1, 1'b0, 8'h00, 8'h08, 8'h00};
    vecs[4] = '{2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 8'h00, 8'h0D, 8'h1A};

    preload(2'd0, 8'h00);
    preload(2'd1, 8'h05);
    preload(2'd2, 8'h03);
    preload(2'd3, 8'h00);

    @(negedge clk);
    chk("reset_ready1", i1.INS_READY, 0);
    chk("reset_ready4", i4.INS_READY, 0);
    chk("reset_en1", en1, 0);
    chk("reset_done1", done1, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_dirwr1", dw1, 0);
    chk("reset_di1", di1, 0);
    chk("reset_alua1", aa1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready1", i1.INS_READY, 1);
    chk("post_reset_busy4", busy4, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    stream();

    preload(2'd1, 8'h10);
    preload(2'd2, 8'h01);
    run_vec('{2'd1, 2'd2, 2'd1, 1'b1, 1'b0, 8'h00, 8'h10, 8'h0F});

    reset_abort();

`ifdef REG_SEQ_LOADI_EN
    run_vec('{2'd2, 2'd3, 2'd0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
